// File: rtl/div_pkg.sv
// Shared definitions for the sequential unsigned divider: default widths,
// FSM state encoding and the quotient reported for a zero divisor.
package div_pkg;

  localparam int unsigned DEF_DIVIDEND_W = 32;
  localparam int unsigned DEF_DIVISOR_W  = 16;

  // Quotient returned when the divisor is zero (default dividend width).
  localparam logic [DEF_DIVIDEND_W-1:0] DIV0_QUOTIENT = {DEF_DIVIDEND_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division step: shifts the next dividend bit into the partial
// remainder and conditionally subtracts the divisor.
// Ports:
//   rem_i      partial remainder before the step (always < divisor)
//   dvd_bit_i  next dividend bit, MSB first
//   divisor_i  divisor (non-zero while stepping)
//   rem_c_o    partial remainder after the step
//   q_bit_c_o  quotient bit produced by the step
module div_step #(
  parameter int unsigned DIVISOR_W = 16
) (
  input  logic [DIVISOR_W-1:0] rem_i,
  input  logic                 dvd_bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W-1:0] rem_c_o,
  output logic                 q_bit_c_o
);

  // One extra bit so the shifted remainder can never overflow.
  logic [DIVISOR_W:0] trial;

  // Trial subtraction; the result is below the divisor so it fits DIVISOR_W bits.
  always_comb begin
    trial     = {rem_i, dvd_bit_i};
    q_bit_c_o = 1'b0;
    rem_c_o   = trial[DIVISOR_W-1:0];
    if (trial >= {1'b0, divisor_i}) begin
      q_bit_c_o = 1'b1;
      rem_c_o   = DIVISOR_W'(trial - {1'b0, divisor_i});
    end
  end

endmodule : div_step

// File: rtl/div_32by16_seq.sv
// Sequential unsigned divider, restoring algorithm, one quotient bit per clock.
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid / in_ready     operand handshake (in_ready high only in IDLE)
//   dividend, divisor       unsigned operands, latched on acceptance
//   out_valid / out_ready   result handshake (out_valid high only in DONE)
//   quotient, remainder     registered result, held while out_ready is low
//   div_by_zero             result came from a zero divisor
module div_32by16_seq
  import div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W) + 1;

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;       // dividend shifts out, quotient shifts in
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;

  logic [DIVISOR_W-1:0]  step_rem_c;
  logic                  step_q_bit_c;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[DIVIDEND_W-1]),
    .divisor_i (dsr_q),
    .rem_c_o   (step_rem_c),
    .q_bit_c_o (step_q_bit_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dvd_d = dividend;
          dsr_d = divisor;
          cnt_d = '0;
          rem_d = '0;
          if (divisor == '0) begin
            // Zero divisor skips the iterations and reports a saturated quotient.
            state_d     = ST_DONE;
            quotient_d  = '1;
            remainder_d = dividend[DIVISOR_W-1:0];
            dbz_d       = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q_bit_c};
        rem_d = step_rem_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
          state_d     = ST_DONE;
          quotient_d  = {dvd_q[DIVIDEND_W-2:0], step_q_bit_c};
          remainder_d = step_rem_c;
          dbz_d       = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule : div_32by16_seq

// File: tb/tb_div_32by16_seq.sv
// Bench for div_32by16_seq: directed vector table, backpressure and reset
// sequences, then random operands with random output stalls.
module tb_div_32by16_seq;

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [SW-1:0] divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          div_by_zero;

  typedef struct {
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic          dbz;
  } exp_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [SW-1:0] b;
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic          dbz;
  } vec_t;

  exp_t sb[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  div_32by16_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [DW-1:0] q, input logic [SW-1:0] r, input logic dbz);
    exp_t e;
    e.q = q;
    e.r = r;
    e.dbz = dbz;
    return e;
  endfunction

  // Reference behaviour from the language's own division operators.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [SW-1:0] b);
    logic [DW-1:0] bw;
    if (b == '0) return mk({DW{1'b1}}, a[SW-1:0], 1'b1);
    bw = {16'h0, b};
    return mk(a / bw, SW'(a % bw), 1'b0);
  endfunction

  // Issue one operation, push its expectation, then drain and compare the result.
  task automatic run_op(input logic [DW-1:0] a, input logic [SW-1:0] b, input exp_t e,
                        input int stall, input bit poke, input bit chk_lat);
    int   n;
    exp_t got;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    sb.push_back(e);
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = SW'($urandom);
    if (chk_lat) check("in_ready_after_accept", 64'(in_ready), 64'(0));
    n = 0;
    while (!out_valid && n < 100) begin
      if (poke) in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      check("result_timeout", 64'(out_valid), 64'(1));
      sb.delete();
      return;
    end
    if (chk_lat) check("latency_edges_after_accept", 64'(n), (b == '0) ? 64'(0) : 64'(DW));
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'(sb.size()), 64'(1));
      return;
    end
    got = sb.pop_front();
    for (int i = 0; i < stall; i++) begin
      if (poke) in_valid = 1'b1;
      check("hold_quotient", 64'(quotient), 64'(got.q));
      check("hold_remainder", 64'(remainder), 64'(got.r));
      check("hold_in_ready", 64'(in_ready), 64'(0));
      check("hold_out_valid", 64'(out_valid), 64'(1));
      @(posedge clk); #1;
    end
    check("quotient", 64'(quotient), 64'(got.q));
    check("remainder", 64'(remainder), 64'(got.r));
    check("div_by_zero", 64'(div_by_zero), 64'(got.dbz));
    // With poke set, in_valid stays high across the consume edge: it must not be taken.
    in_valid  = poke;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("out_valid_after_consume", 64'(out_valid), 64'(0));
    check("in_ready_after_consume", 64'(in_ready), 64'(1));
  endtask

  initial begin
    vec_t          vecs[7];
    logic [DW-1:0] ra;
    logic [SW-1:0] rb;

    vecs[0] = '{32'd100,       16'd7,      32'd14,          16'd2,      1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 16'hFFFF,   32'h0001_0001,   16'h0,      1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 16'h0001,   32'hFFFF_FFFF,   16'h0,      1'b0};
    vecs[3] = '{32'd5,         16'd9,      32'd0,           16'd5,      1'b0};
    vecs[4] = '{32'd0,         16'd3,      32'd0,           16'd0,      1'b0};
    vecs[5] = '{32'd12345,     16'd0,      32'hFFFF_FFFF,   16'h3039,   1'b1};
    vecs[6] = '{32'hFFFF_FFFF, 16'h8000,   32'h0001_FFFF,   16'h7FFF,   1'b0};

    #12;
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_quotient", 64'(quotient), 64'(0));
    check("reset_remainder", 64'(remainder), 64'(0));
    check("reset_div_by_zero", 64'(div_by_zero), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, mk(vecs[i].q, vecs[i].r, vecs[i].dbz), 0, 1'b0, 1'b1);
    end

    // Backpressure in DONE with in_valid pulses during CALC and DONE.
    run_op(32'd100, 16'd7, mk(32'd14, 16'd2, 1'b0), 10, 1'b1, 1'b1);
    run_op(32'd12345, 16'd0, mk(32'hFFFF_FFFF, 16'h3039, 1'b1), 10, 1'b1, 1'b1);

    // Asynchronous reset in the middle of CALC drops the operation.
    dividend = 32'h0000_ABCD;
    divisor  = 16'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("calc_before_reset_in_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b0;
    #1;
    check("midcalc_reset_out_valid", 64'(out_valid), 64'(0));
    check("midcalc_reset_in_ready", 64'(in_ready), 64'(1));
    check("midcalc_reset_quotient", 64'(quotient), 64'(0));
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'd1000, 16'd10, mk(32'd100, 16'd0, 1'b0), 0, 1'b0, 1'b1);

    for (int k = 0; k < 200; k++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = DW'($urandom_range(0, 70000));
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 16'd1;
        2:       rb = 16'hFFFF;
        3:       rb = SW'($urandom_range(1, 20));
        default: rb = SW'($urandom);
      endcase
      run_op(ra, rb, model(ra, rb), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule : tb_div_32by16_seq
